// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes IF word fetches and MEM byte/half/word accesses onto a
// single 8-bit synchronous RAM port, one byte per cycle, little-endian.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned ByteW = 8;
    localparam int unsigned CntW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_d;
    logic              owner_mem, owner_mem_d;
    logic              we_q, we_d;
    logic [AddrW-1:0]  base, base_d;
    logic [DataW-1:0]  wdata_q, wdata_d;
    logic [CntW-1:0]   nbytes, nbytes_d;
    logic [CntW-1:0]   cnt, cnt_d;
    logic [DataW-1:0]  acc, acc_d;
    logic              last_mem, last_mem_d;
    logic [AddrW-1:0]  ram_addr_d;
    logic [ByteW-1:0]  ram_wdata_d;
    logic              ram_we_d;
    logic [DataW-1:0]  if_inst_d, mem_rdata_d;
    logic              if_done_d, mem_done_d;
    logic              grant_mem;
    logic              cap_en;
    logic [1:0]        cap_idx;

    // Select byte i of a word.
    function automatic logic [ByteW-1:0] byte_sel(input logic [DataW-1:0] w, input logic [1:0] i);
        logic [ByteW-1:0] b;
        case (i)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner_mem <= 1'b0;
            we_q      <= 1'b0;
            base      <= '0;
            wdata_q   <= '0;
            nbytes    <= '0;
            cnt       <= '0;
            acc       <= '0;
            last_mem  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            if_inst   <= '0;
            if_done   <= 1'b0;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
        end else begin
            state     <= state_d;
            owner_mem <= owner_mem_d;
            we_q      <= we_d;
            base      <= base_d;
            wdata_q   <= wdata_d;
            nbytes    <= nbytes_d;
            cnt       <= cnt_d;
            acc       <= acc_d;
            last_mem  <= last_mem_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            ram_we    <= ram_we_d;
            if_inst   <= if_inst_d;
            if_done   <= if_done_d;
            mem_rdata <= mem_rdata_d;
            mem_done  <= mem_done_d;
        end
    end

    // Next-state, arbitration, RAM sequencing and read-byte capture.
    always_comb begin
        state_d     = state;
        owner_mem_d = owner_mem;
        we_d        = we_q;
        base_d      = base;
        wdata_d     = wdata_q;
        nbytes_d    = nbytes;
        cnt_d       = cnt;
        acc_d       = acc;
        last_mem_d  = last_mem;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        ram_we_d    = 1'b0;
        if_inst_d   = if_inst;
        if_done_d   = 1'b0;
        mem_rdata_d = mem_rdata;
        mem_done_d  = 1'b0;
        grant_mem   = 1'b0;

        // Read data for byte k arrives the cycle after byte k was addressed.
        cap_idx = 2'(cnt - 3'd1);
        cap_en  = ((state == XFER) && !we_q && (cnt != '0)) || (state == WAIT);
        if (cap_en) begin
            case (cap_idx)
                2'd0:    acc_d[7:0]   = ram_rdata;
                2'd1:    acc_d[15:8]  = ram_rdata;
                2'd2:    acc_d[23:16] = ram_rdata;
                default: acc_d[31:24] = ram_rdata;
            endcase
        end

        case (state)
            IDLE: begin
                if (if_req || mem_req) begin
                    // MEM wins a tie unless it won the previous grant.
                    grant_mem   = mem_req && (!if_req || !last_mem);
                    owner_mem_d = grant_mem;
                    if (grant_mem) begin
                        we_d    = mem_we;
                        base_d  = mem_addr;
                        wdata_d = mem_wdata;
                        case (mem_len)
                            2'b00:   nbytes_d = 3'd1;
                            2'b01:   nbytes_d = 3'd2;
                            default: nbytes_d = 3'd4;
                        endcase
                    end else begin
                        we_d     = 1'b0;
                        base_d   = if_addr;
                        wdata_d  = '0;
                        nbytes_d = 3'd4;
                    end
                    cnt_d       = '0;
                    acc_d       = '0;
                    ram_addr_d  = base_d;
                    ram_we_d    = we_d;
                    ram_wdata_d = byte_sel(wdata_d, 2'd0);
                    state_d     = XFER;
                end
            end
            XFER: begin
                cnt_d = cnt + 3'd1;
                if (cnt == nbytes - 3'd1) begin
                    if (we_q) begin
                        state_d    = DONE;
                        mem_done_d = owner_mem;
                        if_done_d  = !owner_mem;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    ram_addr_d  = base + 32'(cnt_d);
                    ram_we_d    = we_q;
                    ram_wdata_d = byte_sel(wdata_q, cnt_d[1:0]);
                end
            end
            WAIT: begin
                state_d = DONE;
                if (owner_mem) begin
                    mem_rdata_d = acc_d;
                    mem_done_d  = 1'b1;
                end else begin
                    if_inst_d = acc_d;
                    if_done_d = 1'b1;
                end
            end
            DONE: begin
                last_mem_d = owner_mem;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram_mem [0:1023] = '{default: 8'h00};
    logic       written [0:1023] = '{default: 1'b0};

    mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_inst   (if_inst),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Initial RAM image for addresses never stored to.
    function automatic logic [7:0] init_byte(input logic [9:0] a);
        case (a)
            10'h010: return 8'h13;
            10'h011: return 8'h05;
            10'h012: return 8'h10;
            10'h013: return 8'h00;
            10'h007: return 8'h80;
            10'h3FF: return 8'h34;
            10'h000: return 8'h12;
            default: return 8'h00;
        endcase
    endfunction

    // RAM model: 1 KiB aliased, read-first, data one cycle after address.
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr[9:0]] <= ram_wdata;
            written[ram_addr[9:0]] <= 1'b1;
        end
        ram_rdata <= written[ram_addr[9:0]] ? ram_mem[ram_addr[9:0]] : init_byte(ram_addr[9:0]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // IF fetch from 0x10 issued in the current cycle T; checks through T+6.
    task automatic fetch_check(input string tag);
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k <= 4) begin
                check($sformatf("%s_addr%0d", tag, k), ram_addr, 32'h10 + 32'(k - 1));
                check($sformatf("%s_we%0d", tag, k), 32'(ram_we), 32'h0);
            end
            check($sformatf("%s_done%0d", tag, k), 32'(if_done), 32'(k == 6));
            check($sformatf("%s_mdone%0d", tag, k), 32'(mem_done), 32'h0);
        end
        check($sformatf("%s_inst", tag), if_inst, 32'h0010_0513);
        if_req = 1'b0;
        step();
        check($sformatf("%s_done_pulse", tag), 32'(if_done), 32'h0);
        check($sformatf("%s_inst_held", tag), if_inst, 32'h0010_0513);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] evs;
        int         n_ev;
        logic       both;
        logic [31:0] exp_wd;

        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_len   = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        repeat (2) @(posedge clk);
        step();

        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_if_done", 32'(if_done), 32'h0);
        check("rst_mem_done", 32'(mem_done), 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b1;

        fetch_check("fetch1");

        // Word store 0xDEADBEEF to 0x100.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_len   = 2'b10;
        mem_addr  = 32'h0000_0100;
        mem_wdata = 32'hDEAD_BEEF;
        exp_wd    = 32'hDEAD_BEEF;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k <= 4) begin
                check($sformatf("st_we%0d", k), 32'(ram_we), 32'h1);
                check($sformatf("st_addr%0d", k), ram_addr, 32'h100 + 32'(k - 1));
                check($sformatf("st_wdata%0d", k), 32'(ram_wdata), 32'(exp_wd[7:0]));
                exp_wd = exp_wd >> 8;
            end else begin
                check("st_we_off", 32'(ram_we), 32'h0);
            end
            check($sformatf("st_done%0d", k), 32'(mem_done), 32'(k == 5));
            check($sformatf("st_ifdone%0d", k), 32'(if_done), 32'h0);
        end
        mem_req = 1'b0;
        mem_we  = 1'b0;
        step();
        check("st_ram_image", {ram_mem[10'h103], ram_mem[10'h102], ram_mem[10'h101], ram_mem[10'h100]},
              32'hDEAD_BEEF);
        check("st_done_pulse", 32'(mem_done), 32'h0);

        // Byte load from 0x7.
        mem_req  = 1'b1;
        mem_len  = 2'b00;
        mem_addr = 32'h0000_0007;
        step();
        check("bl_addr", ram_addr, 32'h7);
        step();
        check("bl_done2", 32'(mem_done), 32'h0);
        step();
        check("bl_done3", 32'(mem_done), 32'h1);
        check("bl_rdata", mem_rdata, 32'h0000_0080);
        mem_req = 1'b0;
        step();
        check("bl_rdata_held", mem_rdata, 32'h0000_0080);

        // Both requesting continuously: grants must alternate, MEM first after reset.
        do_reset();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0010;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_len  = 2'b00;
        mem_addr = 32'h0000_0007;
        evs  = '0;
        n_ev = 0;
        both = 1'b0;
        for (int i = 0; i < 80 && n_ev < 4; i++) begin
            step();
            if (if_done && mem_done) both = 1'b1;
            if (mem_done) begin
                evs[n_ev] = 1'b1;
                n_ev++;
                check($sformatf("arb_mrdata%0d", n_ev), mem_rdata, 32'h0000_0080);
            end else if (if_done) begin
                evs[n_ev] = 1'b0;
                n_ev++;
                check($sformatf("arb_inst%0d", n_ev), if_inst, 32'h0010_0513);
            end
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        check("arb_count", 32'(n_ev), 32'd4);
        check("arb_no_both", 32'(both), 32'h0);
        check("arb_order", 32'(evs), 32'b0101);

        // Half load at 0xFFFFFFFF wraps to 0x0.
        do_reset();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_len  = 2'b01;
        mem_addr = 32'hFFFF_FFFF;
        step();
        check("hl_addr1", ram_addr, 32'hFFFF_FFFF);
        step();
        check("hl_addr2", ram_addr, 32'h0000_0000);
        step();
        check("hl_done3", 32'(mem_done), 32'h0);
        step();
        check("hl_done4", 32'(mem_done), 32'h1);
        check("hl_rdata", mem_rdata, 32'h0000_1234);
        mem_req = 1'b0;
        step();

        // Reset during a word store aborts it; a later fetch still works.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_len   = 2'b10;
        mem_addr  = 32'h0000_0200;
        mem_wdata = 32'h1122_3344;
        step();
        check("ab_we1", 32'(ram_we), 32'h1);
        check("ab_wdata1", 32'(ram_wdata), 32'h44);
        step();
        check("ab_addr2", ram_addr, 32'h201);
        check("ab_wdata2", 32'(ram_wdata), 32'h33);
        rst     = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        step();
        check("ab_we_off", 32'(ram_we), 32'h0);
        check("ab_no_done", 32'(mem_done), 32'h0);
        check("ab_ram_addr", ram_addr, 32'h0);
        check("ab_partial", 32'(ram_mem[10'h200]), 32'h44);
        rst = 1'b1;
        fetch_check("fetch2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
